// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and constants for the clock-gate enable controller.
package clock_gate_ctrl_pkg;

    // Controller states; encoding 2'b11 is unused and recovers to RUN.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } cgc_state_t;

    localparam int                  GATE_COUNT_W   = 16;
    localparam logic [GATE_COUNT_W-1:0] GATE_COUNT_MAX = 16'hFFFF;

    // Saturating increment for the gating-event counter.
    function automatic logic [GATE_COUNT_W-1:0] sat_inc(input logic [GATE_COUNT_W-1:0] value);
        if (value == GATE_COUNT_MAX) begin
            return value;
        end
        return value + 16'd1;
    endfunction

endpackage

// File: rtl/clock_gate_ctrl_timer.sv
// 16-bit loadable down-counter shared by the idle-hysteresis and wake phases.
// Decrementing stops at zero so a stray decrement request cannot wrap.
module clock_gate_ctrl_timer #(
    parameter logic [15:0] RESET_VAL = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic        zero
);

    logic [15:0] count;

    // Load has priority over decrement; reset restores the idle reload value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/clock_gate_ctrl.sv
// Enable-side controller for a clock gate cell: applies idle hysteresis before
// dropping clken, and runs a wake handshake that acknowledges requestors once
// the gated clock has been running for WAKE_CYCLES cycles.
module clock_gate_ctrl
    import clock_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        busy,
    input  logic        wake_req,
    input  logic        force_on,
    output logic        clken,
    output logic        wake_ack,
    output logic        gated,
    output logic [15:0] gate_count
);

    // Reject out-of-range hysteresis or wake delays at elaboration.
    if (IDLE_CYCLES < 1 || IDLE_CYCLES > 65535) begin : g_bad_idle
        $error("clock_gate_ctrl: IDLE_CYCLES must be in 1..65535");
    end
    if (WAKE_CYCLES < 1 || WAKE_CYCLES > 65535) begin : g_bad_wake
        $error("clock_gate_ctrl: WAKE_CYCLES must be in 1..65535");
    end

    localparam logic [15:0] IDLE_RELOAD = 16'(IDLE_CYCLES - 1);
    localparam logic [15:0] WAKE_RELOAD = 16'(WAKE_CYCLES - 1);

    cgc_state_t        state;
    cgc_state_t        state_next;
    logic              clken_next;
    logic              gated_next;
    logic              wake_ack_next;
    logic [15:0]       gate_count_next;
    logic              timer_load;
    logic [15:0]       timer_load_val;
    logic              timer_dec;
    logic              timer_zero;
    logic              idle;

    // Any activity, wake request or override keeps the domain awake.
    assign idle = !busy && !wake_req && !force_on;

    clock_gate_ctrl_timer #(
        .RESET_VAL (IDLE_RELOAD)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // Next-state, next-output and timer control; all outputs are registered
    // so clken never has a combinational path from the inputs.
    always_comb begin
        state_next      = state;
        clken_next      = 1'b1;
        gated_next      = 1'b0;
        wake_ack_next   = 1'b0;
        gate_count_next = gate_count;
        timer_load      = 1'b0;
        timer_load_val  = IDLE_RELOAD;
        timer_dec       = 1'b0;

        case (state)
            RUN: begin
                if (!idle) begin
                    // Activity wins over an expiring timer; a request seen
                    // while the clock is already running is acked next cycle.
                    timer_load    = 1'b1;
                    wake_ack_next = wake_req;
                end else if (timer_zero) begin
                    state_next      = GATED;
                    clken_next      = 1'b0;
                    gated_next      = 1'b1;
                    gate_count_next = sat_inc(gate_count);
                end else begin
                    timer_dec = 1'b1;
                end
            end

            GATED: begin
                if (!idle) begin
                    // Re-enable the clock at this edge and start the wake delay.
                    state_next     = WAKE;
                    timer_load     = 1'b1;
                    timer_load_val = WAKE_RELOAD;
                end else begin
                    clken_next = 1'b0;
                    gated_next = 1'b1;
                end
            end

            WAKE: begin
                // Inputs are ignored until the clock has run long enough; the
                // ack is issued whatever caused the wake.
                if (timer_zero) begin
                    state_next    = RUN;
                    wake_ack_next = 1'b1;
                    timer_load    = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            default: begin
                // Unused encoding: recover to RUN with the clock enabled.
                state_next = RUN;
                timer_load = 1'b1;
            end
        endcase
    end

    // State and output registers; reset leaves the clock enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            clken      <= 1'b1;
            gated      <= 1'b0;
            wake_ack   <= 1'b0;
            gate_count <= '0;
        end else begin
            state      <= state_next;
            clken      <= clken_next;
            gated      <= gated_next;
            wake_ack   <= wake_ack_next;
            gate_count <= gate_count_next;
        end
    end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl with a cycle-level reference model.
module tb_clock_gate_ctrl;

    localparam int IDLE = 4;
    localparam int WAKE_N = 2;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        busy     = 1'b0;
    logic        wake_req = 1'b0;
    logic        force_on = 1'b0;
    logic        clken;
    logic        wake_ack;
    logic        gated;
    logic [15:0] gate_count;

    clock_gate_ctrl #(
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE_N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy       (busy),
        .wake_req   (wake_req),
        .force_on   (force_on),
        .clken      (clken),
        .wake_ack   (wake_ack),
        .gated      (gated),
        .gate_count (gate_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counts consecutive idle samples while running, and the
    // remaining wake cycles after an ungate.
    int idle_streak;
    bit m_gated;
    int wake_left;
    bit m_ack;
    int m_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        idle_streak = 0;
        m_gated     = 1'b0;
        wake_left   = 0;
        m_ack       = 1'b0;
        m_count     = 0;
    endtask

    task automatic model_step(input bit b, input bit w, input bit f);
        bit active;
        active = b | w | f;
        m_ack  = 1'b0;
        if (wake_left > 0) begin
            wake_left--;
            if (wake_left == 0) begin
                m_ack       = 1'b1;
                idle_streak = 0;
            end
        end else if (m_gated) begin
            if (active) begin
                m_gated   = 1'b0;
                wake_left = WAKE_N;
            end
        end else begin
            m_ack = w;
            if (active) begin
                idle_streak = 0;
            end else begin
                idle_streak++;
                if (idle_streak == IDLE) begin
                    m_gated     = 1'b1;
                    idle_streak = 0;
                    if (m_count < 65535) m_count++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("clken", 32'(clken), 32'(!m_gated));
        check_eq("gated", 32'(gated), 32'(m_gated));
        check_eq("wake_ack", 32'(wake_ack), 32'(m_ack));
        check_eq("gate_count", 32'(gate_count), 32'(m_count));
    endtask

    task automatic cycle(input bit b, input bit w, input bit f);
        busy     = b;
        wake_req = w;
        force_on = f;
        @(posedge clk);
        if (rst_n) model_step(b, w, f);
        else       model_reset();
        #1;
        compare_all();
    endtask

    task automatic gate_then_wake();
        repeat (IDLE) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (WAKE_N) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();

        // Reset applied before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_clken", 32'(clken), 32'd1);
        check_eq("rst_gated", 32'(gated), 32'd0);
        check_eq("rst_count", 32'(gate_count), 32'd0);
        check_eq("rst_ack", 32'(wake_ack), 32'd0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Idle gating after exactly IDLE samples.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (IDLE - 1) cycle(1'b0, 1'b0, 1'b0);
        check_eq("pre_gate", 32'(gated), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("gate_clken", 32'(clken), 32'd0);
        check_eq("gate_gated", 32'(gated), 32'd1);
        check_eq("gate_count1", 32'(gate_count), 32'd1);

        // Wake handshake via wake_req.
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("wake_clken", 32'(clken), 32'd1);
        check_eq("wake_noack", 32'(wake_ack), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("wake_noack2", 32'(wake_ack), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("wake_ack", 32'(wake_ack), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("wake_ack_drop", 32'(wake_ack), 32'd0);

        // Busy pulse on the last idle sample reloads the hysteresis.
        repeat (IDLE - 2) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("reload_nogate", 32'(gated), 32'd0);
        repeat (IDLE - 1) cycle(1'b0, 1'b0, 1'b0);
        check_eq("reload_nogate2", 32'(gated), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("reload_gate", 32'(gated), 32'd1);
        check_eq("gate_count2", 32'(gate_count), 32'd2);

        // Wake caused by busy still acks.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (WAKE_N) cycle(1'b0, 1'b0, 1'b0);
        check_eq("busy_wake_ack", 32'(wake_ack), 32'd1);

        // Request while running: one ack next cycle, clken held.
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("run_ack", 32'(wake_ack), 32'd1);
        check_eq("run_clken", 32'(clken), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("run_ack_drop", 32'(wake_ack), 32'd0);

        // Override keeps the clock running.
        repeat (100) cycle(1'b0, 1'b0, 1'b1);
        check_eq("force_nogate", 32'(gated), 32'd0);
        check_eq("force_count", 32'(gate_count), 32'd2);

        // Randomized traffic.
        repeat (1500) begin
            int r;
            r = $urandom_range(0, 15);
            cycle(r < 3, r == 3, r == 4);
        end

        // Return to running, then preload the counter near saturation.
        repeat (WAKE_N + 2) cycle(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        force dut.gate_count = 16'hFFFE;
        #1;
        release dut.gate_count;
        m_count = 32'hFFFE;
        check_eq("preload", 32'(gate_count), 32'hFFFE);
        repeat (3) gate_then_wake();
        check_eq("saturate", 32'(gate_count), 32'hFFFF);

        // Reset in the middle of a wake with one cycle left.
        repeat (IDLE) cycle(1'b0, 1'b0, 1'b0);
        check_eq("pre_midwake_gated", 32'(gated), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_clken", 32'(clken), 32'd1);
        check_eq("midrst_gated", 32'(gated), 32'd0);
        check_eq("midrst_count", 32'(gate_count), 32'd0);
        check_eq("midrst_ack", 32'(wake_ack), 32'd0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("post_rst_ack", 32'(wake_ack), 32'd0);
        repeat (IDLE - 1) cycle(1'b0, 1'b0, 1'b0);
        check_eq("post_rst_gate", 32'(gated), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
